// File: rtl/dmem_responder.sv
// Word-organised data RAM behind valid/ready request and response channels,
// with a programmable access delay so MEM-stage stall logic sees real latency.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset_n,
  input  logic        REQ_valid,
  output logic        REQ_ready,
  input  logic        REQ_write,
  input  logic [31:0] REQ_addr,
  input  logic [31:0] REQ_wdata,
  input  logic [3:0]  REQ_be,
  output logic        RSP_valid,
  input  logic        RSP_ready,
  output logic [31:0] RSP_rdata,
  output logic        RSP_error,
  output logic        DMR_busy
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    be_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        write_r, write_s;
  logic [31:0] addr_r, addr_s;
  logic [31:0] wdata_r, wdata_s;
  logic [3:0]  be_r, be_s;
  logic        rsp_valid_r, rsp_valid_s;
  logic [31:0] rsp_rdata_r, rsp_rdata_s;
  logic        rsp_error_r, rsp_error_s;
  logic        busy_r, busy_s;

  logic [31:0] mem_r [DEPTH_WORDS];
  logic        error_s;
  logic [AW-1:0] idx_s;
  logic [31:0] mem_word_s;
  logic [31:0] mask_s;
  logic        wr_en_s;

  // Access checks always use the captured address, never the live inputs.
  assign error_s    = (addr_r[1:0] != 2'b00) ||
                      ({2'b00, addr_r[31:2]} >= 32'(DEPTH_WORDS));
  assign idx_s      = addr_r[AW+1:2];
  assign mem_word_s = mem_r[idx_s];
  assign mask_s     = be_mask(be_r);
  assign wr_en_s    = (state_r == ST_ACCESS) && write_r && !error_s;

  assign REQ_ready = (state_r == ST_IDLE);
  assign RSP_valid = rsp_valid_r;
  assign RSP_rdata = rsp_rdata_r;
  assign RSP_error = rsp_error_r;
  assign DMR_busy  = busy_r;

  // Next-state and next-register computation for the request/response FSM.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    write_s     = write_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    be_s        = be_r;
    rsp_valid_s = rsp_valid_r;
    rsp_rdata_s = rsp_rdata_r;
    rsp_error_s = rsp_error_r;
    case (state_r)
      ST_IDLE: begin
        if (REQ_valid) begin
          write_s = REQ_write;
          addr_s  = REQ_addr;
          wdata_s = REQ_wdata;
          be_s    = REQ_be;
          cnt_s   = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_s = ST_ACCESS;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_s = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          state_s = ST_ACCESS;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_ACCESS: begin
        cnt_s       = 4'd0;
        rsp_valid_s = 1'b1;
        rsp_error_s = error_s;
        if (write_r || error_s) begin
          rsp_rdata_s = 32'd0;
        end else begin
          rsp_rdata_s = mem_word_s & mask_s;
        end
        state_s = ST_RESP;
      end
      ST_RESP: begin
        if (RSP_ready) begin
          rsp_valid_s = 1'b0;
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        rsp_valid_s = 1'b0;
      end
    endcase
    busy_s = (state_s == ST_WAIT) || (state_s == ST_RESP);
  end

  // Control and response registers; reset aborts any transaction in flight.
  always_ff @(negedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      write_r     <= 1'b0;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      be_r        <= 4'd0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_error_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      write_r     <= write_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      be_r        <= be_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_rdata_r <= rsp_rdata_s;
      rsp_error_r <= rsp_error_s;
      busy_r      <= busy_s;
    end
  end

  // Storage array keeps its contents across reset; byte-masked store.
  always_ff @(negedge SYS_clk) begin
    if (wr_en_s) begin
      mem_r[idx_s] <= (mem_word_s & ~mask_s) | (wdata_r & mask_s);
    end else begin
      mem_r[idx_s] <= mem_word_s;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random traffic
// compared against a byte-level reference memory model.
module tb_dmem_responder;

  localparam int W = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_error, busy;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_error, z_busy;
  logic [31:0] z_rsp_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [2][64];
  logic        cur_w;
  logic [31:0] cur_a, cur_d;
  logic [3:0]  cur_be;
  logic        exp_e;
  logic [31:0] exp_r;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(W)) dut (
    .SYS_clk(clk), .SYS_reset_n(rst_n),
    .REQ_valid(req_valid), .REQ_ready(req_ready), .REQ_write(req_write),
    .REQ_addr(req_addr), .REQ_wdata(req_wdata), .REQ_be(req_be),
    .RSP_valid(rsp_valid), .RSP_ready(rsp_ready), .RSP_rdata(rsp_rdata),
    .RSP_error(rsp_error), .DMR_busy(busy)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .SYS_clk(clk), .SYS_reset_n(rst_n),
    .REQ_valid(z_req_valid), .REQ_ready(z_req_ready), .REQ_write(z_req_write),
    .REQ_addr(z_req_addr), .REQ_wdata(z_req_wdata), .REQ_be(z_req_be),
    .RSP_valid(z_rsp_valid), .RSP_ready(z_rsp_ready), .RSP_rdata(z_rsp_rdata),
    .RSP_error(z_rsp_error), .DMR_busy(z_busy)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Active edge is negedge; sample/drive 2 time units after it.
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Reference: per-byte memory semantics straight from the access rules.
  task automatic model(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic e, output logic [31:0] r);
    int widx;
    e = ((a % 32'd4) != 32'd0) || ((a / 32'd4) >= 32'd64);
    r = 32'd0;
    if (!e) begin
      widx = int'(a / 32'd4);
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          if (w) ref_mem[s][widx][8*b +: 8] = d[8*b +: 8];
          else   r[8*b +: 8] = ref_mem[s][widx][8*b +: 8];
        end
      end
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    cur_w = w; cur_a = a; cur_d = d; cur_be = be;
    step();
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    chk("accept_ready", 32'(req_ready), 32'd0);
  endtask

  // Response must appear W+1 edges after the accepting edge (accept edge = edge 1).
  task automatic await_rsp();
    int n = 0;
    model(0, cur_w, cur_a, cur_d, cur_be, exp_e, exp_r);
    chk("busy_wait", 32'(busy), 32'd1);
    while (rsp_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("latency", 32'(n), 32'(W + 1));
    chk("rsp_error", 32'(rsp_error), 32'(exp_e));
    chk("rsp_rdata", rsp_rdata, exp_r);
    chk("busy_resp", 32'(busy), 32'd1);
  endtask

  task automatic retire();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("retire_valid", 32'(rsp_valid), 32'd0);
    chk("retire_ready", 32'(req_ready), 32'd1);
    chk("retire_busy", 32'(busy), 32'd0);
  endtask

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    issue(w, a, d, be);
    await_rsp();
    retire();
  endtask

  initial begin : main
    logic [31:0] held_r;
    logic [31:0] a;
    logic        t_w [10];
    logic [31:0] t_a [10];
    logic [31:0] t_d [10];
    logic [3:0]  t_be [10];
    logic [32:0] qexp [$];
    int          qacc [$];
    int          acc_edges [$];
    int          idx, nrsp, ea;
    logic        ready_b, e;
    logic [31:0] r;

    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
    rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = 32'd0; z_req_wdata = 32'd0; z_req_be = 4'd0;
    z_rsp_ready = 1'b0;
    #3;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #10;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 64; i++) txn(1'b1, 32'(i * 4), $urandom, 4'hF);

    // Full store then load.
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    issue(1'b0, 32'h10, 32'd0, 4'hF);
    await_rsp();
    chk("t1_load", rsp_rdata, 32'hDEADBEEF);
    retire();

    // Byte-enable store and masked loads.
    txn(1'b1, 32'h10, 32'h000000AA, 4'b0001);
    issue(1'b0, 32'h10, 32'd0, 4'hF);
    await_rsp();
    chk("t2_load_full", rsp_rdata, 32'hDEADBEAA);
    retire();
    issue(1'b0, 32'h10, 32'd0, 4'b1100);
    await_rsp();
    chk("t2_load_hi", rsp_rdata, 32'hDEAD0000);
    retire();

    // Misaligned and out-of-range accesses.
    issue(1'b0, 32'h12, 32'd0, 4'hF);
    await_rsp();
    chk("t3_misalign_err", 32'(rsp_error), 32'd1);
    chk("t3_misalign_data", rsp_rdata, 32'd0);
    retire();
    txn(1'b1, 32'hFC, 32'hCAFEF00D, 4'hF);
    issue(1'b1, 32'h100, 32'h11111111, 4'hF);
    await_rsp();
    chk("t3_range_err", 32'(rsp_error), 32'd1);
    retire();
    issue(1'b0, 32'hFC, 32'd0, 4'hF);
    await_rsp();
    chk("t3_fc_kept", rsp_rdata, 32'hCAFEF00D);
    retire();

    // Back-pressure: response held while a new request waits.
    issue(1'b0, 32'h10, 32'd0, 4'hF);
    await_rsp();
    held_r = exp_r;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h14; req_wdata = 32'd0; req_be = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_valid_held", 32'(rsp_valid), 32'd1);
      chk("t4_rdata_held", rsp_rdata, held_r);
      chk("t4_no_accept", 32'(req_ready), 32'd0);
    end
    retire();
    issue(1'b0, 32'h14, 32'd0, 4'hF);
    await_rsp();
    retire();

    // Reset during WAIT aborts a pending store.
    txn(1'b1, 32'h20, 32'h12345678, 4'hF);
    issue(1'b1, 32'h20, 32'h55, 4'hF);
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_req_ready", 32'(req_ready), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    #1 rst_n = 1'b1;
    step();
    issue(1'b0, 32'h20, 32'd0, 4'hF);
    await_rsp();
    chk("t5_old_value", rsp_rdata, 32'h12345678);
    retire();

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: a = 32'($urandom_range(0, 63)) * 32'd4;
        7, 8:                a = $urandom;
        default:             a = 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(1, 3));
      endcase
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
    end

    // Zero-wait instance at full throughput.
    for (int i = 0; i < 5; i++) begin
      t_w[2*i]    = 1'b1;
      t_a[2*i]    = 32'($urandom_range(0, 63)) * 32'd4;
      t_d[2*i]    = $urandom;
      t_be[2*i]   = 4'hF;
      t_w[2*i+1]  = 1'b0;
      t_a[2*i+1]  = t_a[2*i];
      t_d[2*i+1]  = $urandom;
      t_be[2*i+1] = 4'($urandom);
    end
    t_a[9] = t_a[9] + 32'd2;
    idx = 0; nrsp = 0;
    z_rsp_ready = 1'b1;
    z_req_valid = 1'b1;
    z_req_write = t_w[0]; z_req_addr = t_a[0]; z_req_wdata = t_d[0]; z_req_be = t_be[0];
    for (int edge_n = 1; edge_n <= 80; edge_n++) begin
      ready_b = z_req_ready;
      step();
      if (ready_b && idx < 10) begin
        model(1, t_w[idx], t_a[idx], t_d[idx], t_be[idx], e, r);
        qexp.push_back({e, r});
        qacc.push_back(edge_n);
        acc_edges.push_back(edge_n);
        idx++;
        if (idx < 10) begin
          z_req_write = t_w[idx]; z_req_addr = t_a[idx]; z_req_wdata = t_d[idx]; z_req_be = t_be[idx];
        end else begin
          z_req_valid = 1'b0;
        end
      end
      if (z_rsp_valid === 1'b1) begin
        nrsp++;
        if (qexp.size() == 0) begin
          chk("t6_spurious_rsp", 32'(qexp.size()), 32'd1);
        end else begin
          {e, r} = qexp.pop_front();
          ea = qacc.pop_front();
          chk("t6_latency", 32'(edge_n - ea), 32'd1);
          chk("t6_error", 32'(z_rsp_error), 32'(e));
          chk("t6_rdata", z_rsp_rdata, r);
        end
      end
    end
    chk("t6_accepts", 32'(acc_edges.size()), 32'd10);
    chk("t6_responses", 32'(nrsp), 32'd10);
    for (int i = 1; i < acc_edges.size(); i++)
      chk("t6_spacing", 32'(acc_edges[i] - acc_edges[i-1]), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
